ex_stage: RTL

//  Execute stage of the 5-stage MIPS core, directly downstream of the decode stage. Registers the decode bus,

---
 rtl/ex_stage.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the 5-stage MIPS core.
//
// Registers the decode->execute bus, selects ALU operands, evaluates the
// one-hot ALU, issues data-SRAM requests and forwards its result back to
// decode. Also owns HI/LO and a restoring radix-2 divider for div/divu that
// holds the front of the pipeline through stallreq_for_ex.
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset
//   stall[5:0]       per-stage stall vector, [2]=EX, [3]=MEM, 1 = stop
//   id_to_ex_bus     decode->execute bus (ID_TO_EX_WD bits)
//   ex_to_mem_bus    {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_id_bus     {rf_we, rf_waddr, ex_result} forwarding path
//   inst_is_load     instruction in EX is a load
//   stallreq_for_ex  divider busy, IF/ID/EX must stall
//   data_sram_*      data SRAM request (en, byte wen, byte addr, wdata)

module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_ITER     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_id_bus,
  output logic                    inst_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  localparam int CNT_W = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Two's-complement negation.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a signed 32-bit value (0x80000000 maps to itself, read unsigned).
  function automatic logic [31:0] abs32(input logic [31:0] v);
    if (v[31]) begin
      return neg32(v);
    end else begin
      return v;
    end
  endfunction

  // ---------------------------------------------------------------- input register
  logic [ID_TO_EX_WD-1:0] bus_q;

  // Decode->execute pipeline register: bubble when EX stops but MEM runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
    end else if (stall[2] && !stall[3]) begin
      bus_q <= '0;
    end else if (!stall[2]) begin
      bus_q <= id_to_ex_bus;
    end else begin
      bus_q <= bus_q;
    end
  end

  logic [31:0] pc_s, inst_s, rdata1_s, rdata2_s;
  logic [11:0] alu_op_s;
  logic [2:0]  src1_s;
  logic [3:0]  src2_s;
  logic        ram_en_s, rf_we_s, sel_rf_res_s;
  logic [3:0]  ram_wen_s;
  logic [4:0]  rf_waddr_s;

  assign {pc_s, inst_s, alu_op_s, src1_s, src2_s, ram_en_s, ram_wen_s,
          rf_we_s, rf_waddr_s, sel_rf_res_s, rdata1_s, rdata2_s} = bus_q;

  // ---------------------------------------------------------------- operands / ALU
  logic [31:0] op1_s, op2_s;

  // Selects are one-hot; AND-OR muxing makes an all-zero select yield 0.
  assign op1_s = ({32{src1_s[0]}} & rdata1_s)
               | ({32{src1_s[1]}} & pc_s)
               | ({32{src1_s[2]}} & {27'd0, inst_s[10:6]});

  assign op2_s = ({32{src2_s[0]}} & rdata2_s)
               | ({32{src2_s[1]}} & {{16{inst_s[15]}}, inst_s[15:0]})
               | ({32{src2_s[2]}} & 32'd8)
               | ({32{src2_s[3]}} & {16'd0, inst_s[15:0]});

  logic op_add_s, op_sub_s, op_slt_s, op_sltu_s, op_and_s, op_nor_s;
  logic op_or_s, op_xor_s, op_sll_s, op_srl_s, op_sra_s, op_lui_s;
  assign {op_add_s, op_sub_s, op_slt_s, op_sltu_s, op_and_s, op_nor_s,
          op_or_s, op_xor_s, op_sll_s, op_srl_s, op_sra_s, op_lui_s} = alu_op_s;

  logic [31:0] add_res_s, sub_res_s, slt_res_s, sltu_res_s, sll_res_s, srl_res_s;
  logic [31:0] sra_res_s, lui_res_s, alu_res_s;

  assign add_res_s  = op1_s + op2_s;
  assign sub_res_s  = op1_s - op2_s;
  assign slt_res_s  = {31'd0, ($signed(op1_s) < $signed(op2_s))};
  assign sltu_res_s = {31'd0, (op1_s < op2_s)};
  assign sll_res_s  = op2_s << op1_s[4:0];
  assign srl_res_s  = op2_s >> op1_s[4:0];
  assign sra_res_s  = $unsigned($signed(op2_s) >>> op1_s[4:0]);
  assign lui_res_s  = {op2_s[15:0], 16'd0};

  assign alu_res_s = ({32{op_add_s}}  & add_res_s)
                   | ({32{op_sub_s}}  & sub_res_s)
                   | ({32{op_slt_s}}  & slt_res_s)
                   | ({32{op_sltu_s}} & sltu_res_s)
                   | ({32{op_and_s}}  & (op1_s & op2_s))
                   | ({32{op_nor_s}}  & ~(op1_s | op2_s))
                   | ({32{op_or_s}}   & (op1_s | op2_s))
                   | ({32{op_xor_s}}  & (op1_s ^ op2_s))
                   | ({32{op_sll_s}}  & sll_res_s)
                   | ({32{op_srl_s}}  & srl_res_s)
                   | ({32{op_sra_s}}  & sra_res_s)
                   | ({32{op_lui_s}}  & lui_res_s);

  // ---------------------------------------------------------------- decode of special ops
  logic special_s, is_mfhi_s, is_mflo_s, is_div_s, is_signed_s, divisor_zero_s;

  assign special_s      = (inst_s[31:26] == 6'h00);
  assign is_mfhi_s      = special_s && (inst_s[5:0] == 6'h10);
  assign is_mflo_s      = special_s && (inst_s[5:0] == 6'h12);
  assign is_div_s       = special_s && ((inst_s[5:0] == 6'h1A) || (inst_s[5:0] == 6'h1B));
  assign is_signed_s    = (inst_s[5:0] == 6'h1A);
  assign divisor_zero_s = (rdata2_s == 32'd0);

  // ---------------------------------------------------------------- divider
  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       quo_q, rem_q, dsr_q, dvd_raw_q, hi_q, lo_q;
  logic              div_zero_q, dvd_neg_q, diff_sign_q;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits (33 bits so the shifted value never wraps).
  logic [32:0] trial_s, diff_s;
  logic        fits_s;
  logic [31:0] rem_step_s;

  assign trial_s    = {rem_q, quo_q[31]};
  assign diff_s     = trial_s - {1'b0, dsr_q};
  assign fits_s     = !diff_s[32];
  assign rem_step_s = fits_s ? diff_s[31:0] : trial_s[31:0];

  logic [31:0] lo_fix_s, hi_fix_s;

  // Final HI/LO values: divide-by-zero convention or sign fix-up of magnitudes.
  always_comb begin
    lo_fix_s = quo_q;
    hi_fix_s = rem_q;
    if (div_zero_q) begin
      lo_fix_s = 32'hFFFF_FFFF;
      hi_fix_s = dvd_raw_q;
    end else begin
      if (diff_sign_q) begin
        lo_fix_s = neg32(quo_q);
      end else begin
        lo_fix_s = quo_q;
      end
      if (dvd_neg_q) begin
        hi_fix_s = neg32(rem_q);
      end else begin
        hi_fix_s = rem_q;
      end
    end
  end

  // Divider FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (is_div_s) begin
          if (divisor_zero_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider FSM outputs: hold the pipeline until the DONE cycle.
  always_comb begin
    stallreq_for_ex = 1'b0;
    case (state_q)
      S_IDLE:  stallreq_for_ex = is_div_s;
      S_BUSY:  stallreq_for_ex = 1'b1;
      S_DONE:  stallreq_for_ex = 1'b0;
      default: stallreq_for_ex = 1'b0;
    endcase
  end

  // Divider datapath and HI/LO: latch operands, iterate, commit in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      quo_q       <= 32'd0;
      rem_q       <= 32'd0;
      dsr_q       <= 32'd0;
      dvd_raw_q   <= 32'd0;
      div_zero_q  <= 1'b0;
      dvd_neg_q   <= 1'b0;
      diff_sign_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div_s) begin
            cnt_q       <= '0;
            rem_q       <= 32'd0;
            dvd_raw_q   <= rdata1_s;
            div_zero_q  <= divisor_zero_s;
            dvd_neg_q   <= is_signed_s && rdata1_s[31];
            diff_sign_q <= is_signed_s && (rdata1_s[31] ^ rdata2_s[31]);
            quo_q       <= is_signed_s ? abs32(rdata1_s) : rdata1_s;
            dsr_q       <= is_signed_s ? abs32(rdata2_s) : rdata2_s;
          end
        end
        S_BUSY: begin
          quo_q <= {quo_q[30:0], fits_s};
          rem_q <= rem_step_s;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_DONE: begin
          hi_q <= hi_fix_s;
          lo_q <= lo_fix_s;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [31:0] ex_result_s;
  assign ex_result_s = is_mfhi_s ? hi_q : (is_mflo_s ? lo_q : alu_res_s);

  assign ex_to_mem_bus = {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s,
                          rf_waddr_s, ex_result_s};
  assign ex_to_id_bus  = {rf_we_s, rf_waddr_s, ex_result_s};
  assign inst_is_load  = ram_en_s && (ram_wen_s == 4'd0);

  assign data_sram_en    = ram_en_s && !stallreq_for_ex;
  assign data_sram_wen   = ram_wen_s & {4{!stallreq_for_ex}};
  assign data_sram_addr  = alu_res_s;
  assign data_sram_wdata = rdata2_s;

  logic unused_s;
  assign unused_s = ^{inst_s[25:16], stall[5:4], stall[1:0]};

endmodule
